// File: rtl/button_pkg.sv
// button_pkg: hold-FSM state encoding and counter sizing shared by the button bank.
package button_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, HELD = 2'd2} hold_state_t;
    // A zero-cycle parameter (repeat disabled) still needs a one-bit counter
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/button_bank_if.sv
// button_bank_if: raw button inputs and conditioned event outputs of the bank.
interface button_bank_if #(parameter int CHANNELS = 4);
    logic [CHANNELS-1:0] btn, level, press, rel, hold, rpt;
    modport master(output btn, input level, press, rel, hold, rpt);
    modport slave(input btn, output level, press, rel, hold, rpt);
endinterface

// File: rtl/button_channel.sv
// button_channel: one button's synchroniser, symmetric debouncer and hold/repeat FSM.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1048575,
    parameter int HOLD_CYCLES = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic rel,
    output logic hold,
    output logic rpt
);
    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int RW = cnt_w(REPEAT_CYCLES);
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX = RW'(REPEAT_CYCLES == 0 ? 0 : REPEAT_CYCLES - 1);
    logic [1:0] sync;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic [RW-1:0] rcnt;
    hold_state_t state;
    logic flip;
    // flip marks the edge on which the debounced level changes
    assign flip = (sync[1] != level) && (dcnt == D_MAX);
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            dcnt <= '0;
            hcnt <= '0;
            rcnt <= '0;
            state <= IDLE;
            level <= 1'b0;
            press <= 1'b0;
            rel <= 1'b0;
            hold <= 1'b0;
            rpt <= 1'b0;
        end else begin
            sync <= {sync[0], btn ^ ACTIVE_LOW};
            dcnt <= (sync[1] == level || flip) ? '0 : dcnt + 1'b1;
            level <= level ^ flip;
            press <= flip & ~level;
            rel <= flip & level;
            hold <= 1'b0;
            rpt <= 1'b0;
            // a release suppresses any hold/repeat threshold reached on the same edge
            if (flip && level) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                if (flip) begin
                    state <= PRESSED;
                    hcnt <= '0;
                end
            end else if (state == PRESSED) begin
                if (hcnt == H_MAX) begin
                    state <= HELD;
                    hold <= 1'b1;
                    rcnt <= '0;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end else if (REPEAT_CYCLES != 0) begin
                if (rcnt == R_MAX) begin
                    rpt <= 1'b1;
                    rcnt <= '0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/button_bank.sv
// button_bank: array of independent button conditioners driving level and event strobes.
module button_bank
    import button_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DEBOUNCE_CYCLES = 1048575,
    parameter int HOLD_CYCLES = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic clk,
    input logic rst,
    button_bank_if.slave bus
);
    logic [CHANNELS-1:0] level, press, rel, hold, rpt;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .btn(bus.btn[i]),
            .level(level[i]),
            .press(press[i]),
            .rel(rel[i]),
            .hold(hold[i]),
            .rpt(rpt[i])
        );
    end
    assign bus.level = level;
    assign bus.press = press;
    assign bus.rel = rel;
    assign bus.hold = hold;
    assign bus.rpt = rpt;
endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: three banks (repeat on, repeat off, active-low) checked every cycle against scheduled events.
module tb_button_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_bank_if #(.CHANNELS(2)) b0();
    button_bank_if #(.CHANNELS(2)) b1();
    button_bank_if #(.CHANNELS(2)) b2();
    logic [1:0] lg [3];
    assign b0.btn = lg[0];
    assign b1.btn = lg[1];
    assign b2.btn = ~lg[2];

    button_bank #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b0))
        d0 (.clk(clk), .rst(rst), .bus(b0));
    button_bank #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b0))
        d1 (.clk(clk), .rst(rst), .bus(b1));
    button_bank #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b1))
        d2 (.clk(clk), .rst(rst), .bus(b2));

    logic [9:0] act [3];
    assign act[0] = {b0.level, b0.press, b0.rel, b0.hold, b0.rpt};
    assign act[1] = {b1.level, b1.press, b1.rel, b1.hold, b1.rpt};
    assign act[2] = {b2.level, b2.press, b2.rel, b2.hold, b2.rpt};

    // kind: 0 press, 1 release, 2 hold, 3 repeat, 4 reset (clears all levels)
    typedef struct {int t; int d; int ch; int k;} ev_t;
    ev_t q[$];
    typedef struct {int d; int ch; int len; int p; int h; int r;} vec_t;
    vec_t tbl [10];

    int edge_n = 0;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [1:0] exp_lvl [3];
    logic [1:0] st [3][4];
    logic [9:0] expv;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic push(input int t, input int d, input int ch, input int k);
        q.push_back('{t, d, ch, k});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++)
                for (int k = 0; k < 4; k++) st[d][k] = 2'b00;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].t == edge_n) begin
                    if (q[i].k == 4) begin
                        for (int d = 0; d < 3; d++) exp_lvl[d] = 2'b00;
                    end else begin
                        st[q[i].d][q[i].k][q[i].ch] = 1'b1;
                        if (q[i].k == 0) exp_lvl[q[i].d][q[i].ch] = 1'b1;
                        if (q[i].k == 1) exp_lvl[q[i].d][q[i].ch] = 1'b0;
                    end
                    q.delete(i);
                end
            end
            for (int d = 0; d < 3; d++) begin
                expv = {exp_lvl[d], st[d][0], st[d][1], st[d][2], st[d][3]};
                checks++;
                if (act[d] !== expv) begin
                    errors++;
                    $display("FAIL outputs bank%0d edge %0d got %b want %b (lvl,prs,rel,hld,rpt x2)",
                             d, edge_n, act[d], expv);
                end
            end
        end
    end

    int k0;
    initial begin
        lg = '{2'b00, 2'b00, 2'b00};
        exp_lvl = '{2'b00, 2'b00, 2'b00};
        // {bank, ch, cycles held, press?, hold?, repeats}
        tbl[0] = '{0, 0, 3, 0, 0, 0};
        tbl[1] = '{0, 0, 4, 1, 0, 0};
        tbl[2] = '{0, 1, 8, 1, 0, 0};
        tbl[3] = '{0, 0, 10, 1, 0, 0};
        tbl[4] = '{0, 0, 11, 1, 1, 0};
        tbl[5] = '{0, 0, 13, 1, 1, 0};
        tbl[6] = '{0, 1, 20, 1, 1, 3};
        tbl[7] = '{1, 0, 20, 1, 1, 0};
        tbl[8] = '{2, 1, 14, 1, 1, 1};
        tbl[9] = '{2, 0, 4, 1, 0, 0};

        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        foreach (tbl[i]) begin
            k0 = edge_n;
            lg[tbl[i].d][tbl[i].ch] = 1'b1;
            if (tbl[i].p != 0) begin
                push(k0 + 6, tbl[i].d, tbl[i].ch, 0);
                push(k0 + tbl[i].len + 6, tbl[i].d, tbl[i].ch, 1);
            end
            if (tbl[i].h != 0) push(k0 + 16, tbl[i].d, tbl[i].ch, 2);
            for (int j = 1; j <= tbl[i].r; j++) push(k0 + 16 + 3 * j, tbl[i].d, tbl[i].ch, 3);
            repeat (tbl[i].len) @(negedge clk);
            lg[tbl[i].d][tbl[i].ch] = 1'b0;
            repeat (20) @(negedge clk);
        end

        k0 = edge_n;
        lg[0] = 2'b11;
        for (int c = 0; c < 2; c++) begin
            push(k0 + 6, 0, c, 0);
            push(k0 + 11, 0, c, 1);
        end
        repeat (5) @(negedge clk);
        lg[0] = 2'b00;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            lg[0][0] = 1'b1;
            repeat (2) @(negedge clk);
            lg[0][0] = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (20) @(negedge clk);

        // reset while HELD with the button still down, then re-detection
        k0 = edge_n;
        lg[0][0] = 1'b1;
        push(k0 + 6, 0, 0, 0);
        push(k0 + 16, 0, 0, 2);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].t > edge_n) q.delete(i);
        push(edge_n + 1, 0, 0, 4);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        k0 = edge_n;
        push(k0 + 6, 0, 0, 0);
        repeat (8) @(negedge clk);
        lg[0][0] = 1'b0;
        push(k0 + 14, 0, 0, 1);
        repeat (25) @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
